cnt_wb_engine: RTL
==================

# cnt_wb_engine

Write-back responder for the page access counter. On `cafu_start` from the counter controller it sweeps the counter buffer through the CAFU buffer port and packs counters into 512-bit lines. It writes those lines to host memory starting at `dram_buf_base_addr`, waits for every write response, then returns a one-cycle `cafu_done`. It sits between the counter buffer's port B (selected as CAFU) and the CAFU host-write channel.

## Interface
- `CNT_WIDTH`, 16, width of one counter entry
- `BUF_DEPTH`, 4096, number of counter entries; multiple of `LINE_W/CNT_WIDTH`
- `LINE_W`, 512, host write data width
- `ADDR_W`, `MC_HA_DP_ADDR_WIDTH`, host byte address width
- `MAX_OUTSTANDING`, 8, maximum number of unacknowledged writes
- `clk` in 1: clock
- `reset_n` in 1: synchronous, active-low reset
- `cafu_start` in 1: level request, held high by the controller until it sees `cafu_done`
- `cafu_done` out 1: one-cycle completion pulse
- `dram_buf_base_addr` in `ADDR_W`: destination base address; bits [5:0] ignored and treated as 0
- `buf_rden` out 1: counter buffer read enable
- `buf_addr` out `$clog2(BUF_DEPTH)`: counter buffer entry index
- `buf_rdata` in `CNT_WIDTH`: read data, valid exactly 1 cycle after `buf_rden`
- `wr_valid` out 1: host write request valid
- `wr_ready` in 1: host write request accepted
- `wr_addr` out `ADDR_W`: line byte address
- `wr_data` out `LINE_W`: line payload; entry k sits in bits [k*CNT_WIDTH +: CNT_WIDTH]
- `wr_resp_valid` in 1: one write acknowledged; no backpressure
- `busy` out 1: engine is in any state other than IDLE

## Operation
- Derived constants: EPL = `LINE_W/CNT_WIDTH` (32 by default); NLINES = `BUF_DEPTH/EPL` (128 by default).
- States:
  - IDLE -> FILL on `cafu_start`=1. On entry to FILL, latch the base address, clear the line index, clear the issued count.
  - FILL: each cycle with `buf_rden`=1, read entry line*EPL+j for j = 0..EPL-1, one per cycle.
    - Read issue is stalled, `buf_rden`=0, while outstanding == `MAX_OUTSTANDING`.
    - Data is captured into slot j one cycle after its read.
    - After the last slot is captured, go to ISSUE.
  - ISSUE: hold `wr_valid`=1 with stable `wr_addr` = base + line*64 and stable `wr_data` until `wr_ready`=1.
    - On the handshake, outstanding is incremented and line is incremented.
    - If lines remain, go to FILL; otherwise go to DRAIN.
  - DRAIN: wait until outstanding == 0, then go to DONE.
  - DONE: `cafu_done`=1 for exactly one cycle, then go to WAIT_LOW.
  - WAIT_LOW: wait until `cafu_start`=0, then go to IDLE. This prevents a restart from a stale level.
- Outstanding counter:
  - Width `$clog2(MAX_OUTSTANDING+1)`.
  - +1 on a write handshake, -1 on `wr_resp_valid`; both in the same cycle leaves it unchanged.
  - Decrement at 0 is ignored (saturates at 0); this covers stale responses after reset.
- `cafu_start` dropping before DONE does not abort the sweep.
- Address arithmetic is modulo 2^`ADDR_W`; wrap is silent.

## Timing
- Reset values: all outputs 0; state IDLE; outstanding 0.
- Reset mid-sweep returns to IDLE on the next edge. No partial line is written. In-flight responses are then absorbed by the saturating counter.
- First `buf_rden` occurs in the cycle after `cafu_start` is sampled high in IDLE.
- Per line, with no stall and `wr_ready`=1: EPL read cycles, then 1 capture cycle, then 1 ISSUE cycle = EPL+2 cycles.
- `cafu_done` is asserted the cycle after DRAIN observes outstanding == 0. This includes the case where the final response arrives in the same cycle as the final handshake.
- `wr_valid` never deasserts without a handshake; `wr_data` and `wr_addr` are constant while `wr_valid`=1.

## Structure
- `ctrl_signal_types` gains `wb_state_t` (IDLE, FILL, ISSUE, DRAIN, DONE, WAIT_LOW) and the constant `WB_LINE_BYTES` = 64.
- Sub-module `cnt_line_packer`:
  - Slot-indexed capture register with a `clear` input and a `full` output.
  - The engine owns the FSM, addressing and outstanding tracking.

## Test plan
- Basic sweep (BUF_DEPTH=64, entry i = i, base 0x1000, `wr_ready`=1, response 3 cycles after each write):
  - Exactly 2 writes, to 0x1000 and 0x1040.
  - Line 0 bits[15:0] = 0, bits[511:496] = 31.
  - One `cafu_done` pulse.
- Backpressure: `wr_ready` low for 5 cycles in ISSUE -> `wr_valid`, `wr_addr` and `wr_data` stay unchanged for those 5 cycles; one write per line.
- Outstanding limit (`MAX_OUTSTANDING`=2, responses withheld):
  - After 2 writes, `buf_rden` stays 0.
  - Releasing one response resumes reads within 1 cycle.
- Simultaneous events: handshake and `wr_resp_valid` in the same cycle -> outstanding unchanged; `cafu_done` only after the final response.
- Reset at line 1, slot 10 (reset mid-sweep):
  - Outputs return to 0 and no further writes occur.
  - Late responses do not underflow the counter.
  - A new start performs a full sweep.
- Start held high after done -> no second sweep until `cafu_start` has been low for at least 1 cycle.

Source files
------------

// File: rtl/ctrl_signal_types.sv
// Shared control types for the page access counter: write-back FSM states
// and host line geometry used by the CAFU write-back engine.
package ctrl_signal_types;

  // Host data-path address width used by the CAFU write channel.
  localparam int MC_HA_DP_ADDR_WIDTH = 52;

  // Bytes covered by one 512-bit host write line.
  localparam int WB_LINE_BYTES = 64;

  // Write-back engine states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    ISSUE    = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4,
    WAIT_LOW = 3'd5
  } wb_state_t;

endpackage

// File: rtl/cnt_line_packer.sv
// Slot-indexed capture register that assembles counter entries into one
// host line. Slot k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].
module cnt_line_packer #(
  parameter int CNT_WIDTH = 16,
  parameter int EPL       = 32,
  parameter int SLOT_W    = $clog2(EPL)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     cap_en,
  input  logic [SLOT_W-1:0]        cap_slot,
  input  logic [CNT_WIDTH-1:0]     cap_data,
  output logic                     full,
  output logic [EPL*CNT_WIDTH-1:0] line
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(EPL - 1);

  // The line is complete in the cycle its final slot is written.
  assign full = cap_en && (cap_slot == LAST_SLOT);

  // Capture one entry into its slot; clear wipes the whole line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line <= '0;
    end else if (clear) begin
      line <= '0;
    end else begin
      for (int k = 0; k < EPL; k++) begin
        if (cap_en && (cap_slot == SLOT_W'(k))) begin
          line[k*CNT_WIDTH +: CNT_WIDTH] <= cap_data;
        end
      end
    end
  end

endmodule

// File: rtl/cnt_wb_engine.sv
// CAFU write-back engine: sweeps the counter buffer, packs entries into
// host lines, writes them to host memory and reports completion once every
// write has been acknowledged.
module cnt_wb_engine
  import ctrl_signal_types::*;
#(
  parameter int CNT_WIDTH       = 16,
  parameter int BUF_DEPTH       = 4096,
  parameter int LINE_W          = 512,
  parameter int ADDR_W          = MC_HA_DP_ADDR_WIDTH,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cafu_start,
  output logic                         cafu_done,
  input  logic [ADDR_W-1:0]            dram_buf_base_addr,
  output logic                         buf_rden,
  output logic [$clog2(BUF_DEPTH)-1:0] buf_addr,
  input  logic [CNT_WIDTH-1:0]         buf_rdata,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [LINE_W-1:0]            wr_data,
  input  logic                         wr_resp_valid,
  output logic                         busy
);

  localparam int EPL        = LINE_W / CNT_WIDTH;
  localparam int NLINES     = BUF_DEPTH / EPL;
  localparam int SLOT_W     = $clog2(EPL);
  localparam int LINE_IDX_W = $clog2(NLINES);
  localparam int OS_W       = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(EPL - 1);
  localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(NLINES - 1);
  localparam logic [OS_W-1:0]       OS_MAX    = OS_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0]     LINE_STEP = ADDR_W'(WB_LINE_BYTES);

  wb_state_t               state;
  wb_state_t               state_next;
  logic [LINE_IDX_W-1:0]   line_idx;
  logic [SLOT_W-1:0]       rd_slot;
  logic                    rd_all;
  logic [OS_W-1:0]         outstanding;
  logic [ADDR_W-1:0]       line_addr;
  logic                    cap_en;
  logic [SLOT_W-1:0]       cap_slot;
  logic                    line_full;
  logic                    start_sweep;
  logic                    wr_fire;
  logic                    stall;

  // Low address bits are ignored: lines are always 64-byte aligned.
  logic unused_base_lo;
  assign unused_base_lo = &{1'b0, dram_buf_base_addr[5:0]};

  assign stall    = (outstanding == OS_MAX);
  assign wr_fire  = wr_valid && wr_ready;
  assign busy     = (state != IDLE);
  assign buf_addr = {line_idx, rd_slot};
  assign wr_addr  = line_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_next  = state;
    buf_rden    = 1'b0;
    wr_valid    = 1'b0;
    cafu_done   = 1'b0;
    start_sweep = 1'b0;
    case (state)
      IDLE: begin
        if (cafu_start) begin
          start_sweep = 1'b1;
          state_next  = FILL;
        end else begin
          state_next  = IDLE;
        end
      end
      FILL: begin
        buf_rden = !rd_all && !stall;
        if (line_full) begin
          state_next = ISSUE;
        end else begin
          state_next = FILL;
        end
      end
      ISSUE: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          state_next = (line_idx == LAST_LINE) ? DRAIN : FILL;
        end else begin
          state_next = ISSUE;
        end
      end
      DRAIN: begin
        if (outstanding == OS_W'(0)) begin
          state_next = DONE;
        end else begin
          state_next = DRAIN;
        end
      end
      DONE: begin
        cafu_done  = 1'b1;
        state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!cafu_start) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_LOW;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sweep addressing: line/slot indices, line address and read-capture pipe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_idx  <= '0;
      rd_slot   <= '0;
      rd_all    <= 1'b0;
      line_addr <= '0;
      cap_en    <= 1'b0;
      cap_slot  <= '0;
    end else begin
      cap_en   <= buf_rden;
      cap_slot <= rd_slot;
      if (start_sweep) begin
        line_idx  <= '0;
        rd_slot   <= '0;
        rd_all    <= 1'b0;
        line_addr <= {dram_buf_base_addr[ADDR_W-1:6], 6'b000000};
      end else if (wr_fire) begin
        line_idx  <= line_idx + LINE_IDX_W'(1);
        rd_slot   <= '0;
        rd_all    <= 1'b0;
        line_addr <= line_addr + LINE_STEP;
      end else if (buf_rden) begin
        rd_slot <= rd_slot + SLOT_W'(1);
        rd_all  <= (rd_slot == LAST_SLOT);
      end else begin
        rd_slot <= rd_slot;
      end
    end
  end

  // Unacknowledged write count; a response at zero is a stale one and is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({wr_fire, wr_resp_valid})
        2'b10: outstanding <= outstanding + OS_W'(1);
        2'b01: begin
          if (outstanding != OS_W'(0)) begin
            outstanding <= outstanding - OS_W'(1);
          end else begin
            outstanding <= outstanding;
          end
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

  cnt_line_packer #(
    .CNT_WIDTH (CNT_WIDTH),
    .EPL       (EPL)
  ) u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (start_sweep),
    .cap_en   (cap_en),
    .cap_slot (cap_slot),
    .cap_data (buf_rdata),
    .full     (line_full),
    .line     (wr_data)
  );

endmodule
